// File: rtl/dht11_avg_reporter_if.sv
// Signal bundle between the DHT11 averaging reporter, its upstream sample
// reader and its downstream consumer. DHT11_MINMAX_EN adds the min/max
// temperature outputs.
//
// Handshake: the reporter holds avg_* stable while out_valid=1. An average
// transfers on any posedge where out_valid=1 and out_ready=1. The only case
// where a presented average changes without a transfer is a new sample
// replacing it, which is flagged by the sticky overrun bit.
interface dht11_avg_reporter_if;
   logic [7:0] humidity;
   logic [7:0] temperature;
   logic       valid;
   logic [7:0] avg_humidity;
   logic [7:0] avg_temperature;
   logic       out_valid;
   logic       out_ready;
   logic       overrun;
   logic       reject;
   logic       stale;
`ifdef DHT11_MINMAX_EN
   logic [7:0] min_temperature;
   logic [7:0] max_temperature;
`endif

   // upstream reader plus consumer side
   modport master (
      output humidity, temperature, valid, out_ready,
      input  avg_humidity, avg_temperature, out_valid, overrun, reject, stale
`ifdef DHT11_MINMAX_EN
      , min_temperature, max_temperature
`endif
   );

   // reporter side
   modport slave (
      input  humidity, temperature, valid, out_ready,
      output avg_humidity, avg_temperature, out_valid, overrun, reject, stale
`ifdef DHT11_MINMAX_EN
      , min_temperature, max_temperature
`endif
   );
endinterface

// File: rtl/dht11_avg_reporter.sv
// 4-sample moving average of DHT11 humidity/temperature readings with a
// valid/ready output, range rejection, overrun and stale flags.
// Optional feature macro: DHT11_MINMAX_EN (min/max temperature outputs).
// Pipeline from the posedge that first samples valid high (P0):
//   P1 edge/range qualify, P2 history update, P3 CALC -> OUT (out_valid).
module dht11_avg_reporter #(
   parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
   input  logic                 clk,
   input  logic                 reset,
   dht11_avg_reporter_if.slave  bus,
   output logic [1:0]           state_dbg,
   output logic [2:0]           fill_dbg
);
   localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_CALC = 2'd1,
      ST_OUT  = 2'd2,
      ST_WAIT = 2'd3
   } state_t;

   state_t        state, state_nxt;
   logic          valid_q, valid_qq, armed;
   logic [7:0]    hum_q, tmp_q, hum_c, tmp_c;
   logic          rise, in_range;
   logic          cap_q, rej_q;
   logic [7:0]    hist_h [4];
   logic [7:0]    hist_t [4];
   logic [2:0]    fill_cnt;
   logic          load_avg, ovr_set;
   logic [9:0]    sum_h, sum_t;
   logic [7:0]    avg_h_q, avg_t_q;
   logic          out_valid_q, overrun_q;
   logic [CW-1:0] stale_cnt;

   // Input register. armed stays low while a valid that was high at reset
   // release is still high, so such a level is never taken as a new sample.
   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_q  <= 1'b0;
         valid_qq <= 1'b0;
         armed    <= ~bus.valid;
         hum_q    <= 8'd0;
         tmp_q    <= 8'd0;
      end else begin
         valid_q  <= bus.valid;
         valid_qq <= valid_q;
         armed    <= armed | ~bus.valid;
         hum_q    <= bus.humidity;
         tmp_q    <= bus.temperature;
      end
   end

   assign rise     = valid_q & ~valid_qq & armed;
   assign in_range = (hum_q <= 8'd100) && (tmp_q <= 8'd60);

   // Qualify stage: split a new sample into accept or a one-cycle reject.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cap_q <= 1'b0;
         rej_q <= 1'b0;
         hum_c <= 8'd0;
         tmp_c <= 8'd0;
      end else begin
         cap_q <= rise & in_range;
         rej_q <= rise & ~in_range;
         if (rise) begin
            hum_c <= hum_q;
            tmp_c <= tmp_q;
         end
      end
   end

   // History shift and saturating fill count on every accepted sample.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) begin
            hist_h[i] <= 8'd0;
            hist_t[i] <= 8'd0;
         end
         fill_cnt <= 3'd0;
      end else if (cap_q) begin
         for (int i = 3; i > 0; i--) begin
            hist_h[i] <= hist_h[i-1];
            hist_t[i] <= hist_t[i-1];
         end
         hist_h[0] <= hum_c;
         hist_t[0] <= tmp_c;
         if (fill_cnt != 3'd4) fill_cnt <= fill_cnt + 3'd1;
      end
   end

   // Truncating means over the four history entries.
   always_comb begin
      sum_h = 10'(hist_h[0]) + 10'(hist_h[1]) + 10'(hist_h[2]) + 10'(hist_h[3]);
      sum_t = 10'(hist_t[0]) + 10'(hist_t[1]) + 10'(hist_t[2]) + 10'(hist_t[3]);
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!reset) state <= ST_FILL;
      else        state <= state_nxt;
   end

   // FSM next state, average load strobe and overrun detection.
   always_comb begin
      state_nxt = state;
      load_avg  = 1'b0;
      ovr_set   = 1'b0;
      case (state)
         ST_FILL: if (cap_q && fill_cnt == 3'd3) state_nxt = ST_CALC;
         ST_CALC: begin
            if (!cap_q) begin
               load_avg  = 1'b1;
               state_nxt = ST_OUT;
            end
         end
         ST_OUT: begin
            if (cap_q) begin
               state_nxt = ST_CALC;
               ovr_set   = ~bus.out_ready;
            end else if (bus.out_ready) begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: if (cap_q) state_nxt = ST_CALC;
         default: state_nxt = ST_FILL;
      endcase
   end

   // Output channel: averages load on CALC -> OUT; out_valid drops on transfer.
   always_ff @(posedge clk) begin
      if (!reset) begin
         avg_h_q     <= 8'd0;
         avg_t_q     <= 8'd0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         if (load_avg) begin
            avg_h_q     <= sum_h[9:2];
            avg_t_q     <= sum_t[9:2];
            out_valid_q <= 1'b1;
         end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
         if (ovr_set) overrun_q <= 1'b1;
      end
   end

   // Cycles since the last accepted sample, saturating at the timeout.
   always_ff @(posedge clk) begin
      if (!reset)                                    stale_cnt <= '0;
      else if (cap_q)                                stale_cnt <= '0;
      else if (stale_cnt < CW'(TIMEOUT_CYCLES))      stale_cnt <= stale_cnt + CW'(1);
   end

`ifdef DHT11_MINMAX_EN
   logic [7:0] min_t, max_t, min_q, max_q;

   // Extremes of the temperature history.
   always_comb begin
      min_t = hist_t[0];
      max_t = hist_t[0];
      for (int i = 1; i < 4; i++) begin
         if (hist_t[i] < min_t) min_t = hist_t[i];
         if (hist_t[i] > max_t) max_t = hist_t[i];
      end
   end

   // Min/max registers load together with the averages.
   always_ff @(posedge clk) begin
      if (!reset) begin
         min_q <= 8'd0;
         max_q <= 8'd0;
      end else if (load_avg) begin
         min_q <= min_t;
         max_q <= max_t;
      end
   end

   assign bus.min_temperature = min_q;
   assign bus.max_temperature = max_q;
`endif

   assign bus.avg_humidity    = avg_h_q;
   assign bus.avg_temperature = avg_t_q;
   assign bus.out_valid       = out_valid_q;
   assign bus.overrun         = overrun_q;
   assign bus.reject          = rej_q;
   assign bus.stale           = (stale_cnt >= CW'(TIMEOUT_CYCLES));
   assign state_dbg           = state;
   assign fill_dbg            = fill_cnt;
endmodule

// File: tb/tb_dht11_avg_reporter.sv
// Bench for dht11_avg_reporter: directed samples, a sample-level reference
// model compared every cycle, and hand-computed literal expectations.
module tb_dht11_avg_reporter;
  localparam int TMO = 100;

  logic       clk;
  logic       reset;
  logic [1:0] state_dbg;
  logic [2:0] fill_dbg;
  int         errors = 0;
  int         checks = 0;

  dht11_avg_reporter_if bus_if ();

  dht11_avg_reporter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if),
    .state_dbg (state_dbg),
    .fill_dbg  (fill_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: sample events travel with due cycles, averages come
  // from a queue holding the last four accepted samples
  typedef struct {
    logic [7:0] h;
    logic [7:0] t;
    int         at;
  } ev_t;

  ev_t        q_qual[$];
  ev_t        q_acc[$];
  logic [7:0] hist_h[$];
  logic [7:0] hist_t[$];
  int         cyc = 0;
  int         calc_at = -1;
  bit         model_live = 0;
  bit         m_prev = 0, m_armed = 0;
  int         m_fill = 0, m_stale_cnt = 0;
  logic [7:0] m_avg_h = 0, m_avg_t = 0, m_min_t = 0, m_max_t = 0;
  logic       m_out_valid = 0, m_overrun = 0, m_reject = 0;

  always @(posedge clk) begin
    ev_t e;
    bit  acc;
    int  s_h, s_t;
    cyc = cyc + 1;
    acc = 0;
    if (!reset) begin
      q_qual.delete(); q_acc.delete(); hist_h.delete(); hist_t.delete();
      m_fill = 0; m_stale_cnt = 0; calc_at = -1;
      m_avg_h = 0; m_avg_t = 0; m_min_t = 0; m_max_t = 0;
      m_out_valid = 0; m_overrun = 0; m_reject = 0;
      m_prev = 0; m_armed = !bus_if.valid;
      model_live = 1;
    end else begin
      m_reject = 0;
      if (q_acc.size() > 0 && q_acc[0].at == cyc) begin
        e = q_acc.pop_front();
        acc = 1;
      end
      if (q_qual.size() > 0 && q_qual[0].at == cyc) begin
        ev_t r;
        r = q_qual.pop_front();
        if (r.h > 100 || r.t > 60) m_reject = 1;
        else begin
          r.at = cyc + 1;
          q_acc.push_back(r);
        end
      end
      if (bus_if.valid && !m_prev && m_armed) begin
        ev_t n;
        n.h = bus_if.humidity; n.t = bus_if.temperature; n.at = cyc + 1;
        q_qual.push_back(n);
      end
      m_prev = bus_if.valid;
      if (!bus_if.valid) m_armed = 1;
      if (acc && m_out_valid && !bus_if.out_ready) m_overrun = 1;
      if (m_out_valid && bus_if.out_ready) m_out_valid = 0;
      if (calc_at == cyc) begin
        s_h = 0; s_t = 0;
        m_min_t = hist_t[0]; m_max_t = hist_t[0];
        foreach (hist_h[i]) begin
          s_h += hist_h[i];
          s_t += hist_t[i];
          if (hist_t[i] < m_min_t) m_min_t = hist_t[i];
          if (hist_t[i] > m_max_t) m_max_t = hist_t[i];
        end
        m_avg_h = 8'(s_h / 4);
        m_avg_t = 8'(s_t / 4);
        m_out_valid = 1;
      end
      if (acc) begin
        hist_h.push_front(e.h);
        hist_t.push_front(e.t);
        if (hist_h.size() > 4) begin
          void'(hist_h.pop_back());
          void'(hist_t.pop_back());
        end
        if (m_fill < 4) m_fill++;
        if (m_fill == 4) calc_at = cyc + 1;
        m_stale_cnt = 0;
      end else if (m_stale_cnt < TMO) begin
        m_stale_cnt++;
      end
    end
  end

  // scoreboard compare, every cycle once the model has seen reset
  always @(negedge clk) begin
    if (model_live) begin
      chk("avg_humidity",    32'(bus_if.avg_humidity),    32'(m_avg_h));
      chk("avg_temperature", 32'(bus_if.avg_temperature), 32'(m_avg_t));
      chk("out_valid",       32'(bus_if.out_valid),       32'(m_out_valid));
      chk("overrun",         32'(bus_if.overrun),         32'(m_overrun));
      chk("reject",          32'(bus_if.reject),          32'(m_reject));
      chk("stale",           32'(bus_if.stale),           32'(m_stale_cnt >= TMO));
      chk("fill_count",      32'(fill_dbg),               32'(m_fill));
`ifdef DHT11_MINMAX_EN
      chk("min_temperature", 32'(bus_if.min_temperature), 32'(m_min_t));
      chk("max_temperature", 32'(bus_if.max_temperature), 32'(m_max_t));
`endif
    end
  end

  // driver tasks
  task automatic send(input logic [7:0] h, input logic [7:0] t);
    bus_if.humidity    = h;
    bus_if.temperature = t;
    bus_if.valid       = 1'b1;
    @(negedge clk);
    bus_if.valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    bus_if.valid = 1'b0;
    bus_if.humidity = 8'd0;
    bus_if.temperature = 8'd0;
    bus_if.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(bus_if.out_valid), 0);
    chk("rst_avg_h", 32'(bus_if.avg_humidity), 0);
    chk("rst_state", 32'(state_dbg), 0);
    reset = 1'b1;

    // stale after exactly TMO idle cycles
    repeat (TMO - 1) @(negedge clk);
    chk("stale_before_tmo", 32'(bus_if.stale), 0);
    @(negedge clk);
    chk("stale_at_tmo", 32'(bus_if.stale), 1);

    // four samples with consumer ready; latency and mean
    send(8'd40, 8'd20);
    chk("stale_not_yet_cleared", 32'(bus_if.stale), 1);
    send(8'd42, 8'd22);
    send(8'd44, 8'd24);
    bus_if.humidity = 8'd46; bus_if.temperature = 8'd26; bus_if.valid = 1'b1;
    @(negedge clk);
    bus_if.valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("latency_early", 32'(bus_if.out_valid), 0);
    chk("stale_cleared", 32'(bus_if.stale), 0);
    @(negedge clk);
    chk("latency_rise", 32'(bus_if.out_valid), 1);
    chk("avg_h_43", 32'(bus_if.avg_humidity), 43);
    chk("avg_t_23", 32'(bus_if.avg_temperature), 23);
    chk("no_overrun", 32'(bus_if.overrun), 0);
    @(negedge clk);
    chk("handshake_drop", 32'(bus_if.out_valid), 0);

    // held-high valid counts once
    do_reset();
    bus_if.humidity = 8'd50; bus_if.temperature = 8'd25; bus_if.valid = 1'b1;
    repeat (1000) @(negedge clk);
    chk("held_fill_1", 32'(fill_dbg), 1);
    chk("held_no_out", 32'(bus_if.out_valid), 0);
    bus_if.valid = 1'b0;
    @(negedge clk);

    // valid high across reset release is ignored until it re-rises
    bus_if.valid = 1'b1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_held_fill_0", 32'(fill_dbg), 0);
    bus_if.valid = 1'b0;
    @(negedge clk);
    send(8'd50, 8'd25);
    @(negedge clk);
    chk("rerise_fill_1", 32'(fill_dbg), 1);

    // out-of-range sample is rejected, boundary sample accepted
    bus_if.humidity = 8'd101; bus_if.temperature = 8'd20; bus_if.valid = 1'b1;
    @(negedge clk);
    bus_if.valid = 1'b0;
    chk("reject_early", 32'(bus_if.reject), 0);
    @(negedge clk);
    chk("reject_pulse", 32'(bus_if.reject), 1);
    @(negedge clk);
    chk("reject_end", 32'(bus_if.reject), 0);
    @(negedge clk);
    chk("reject_fill", 32'(fill_dbg), 1);
    send(8'd100, 8'd60);
    @(negedge clk);
    chk("boundary_fill_2", 32'(fill_dbg), 2);

    // overrun with consumer stalled
    bus_if.out_ready = 1'b0;
    send(8'd30, 8'd10);
    send(8'd70, 8'd40);
    repeat (3) @(negedge clk);
    chk("stall_valid", 32'(bus_if.out_valid), 1);
    chk("stall_avg_h_62", 32'(bus_if.avg_humidity), 62);
    chk("stall_avg_t_33", 32'(bus_if.avg_temperature), 33);
    chk("stall_no_overrun", 32'(bus_if.overrun), 0);
    send(8'd60, 8'd30);
    repeat (3) @(negedge clk);
    chk("ovr_valid", 32'(bus_if.out_valid), 1);
    chk("ovr_avg_h_65", 32'(bus_if.avg_humidity), 65);
    chk("ovr_avg_t_35", 32'(bus_if.avg_temperature), 35);
    chk("ovr_set", 32'(bus_if.overrun), 1);
    bus_if.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("ovr_sticky", 32'(bus_if.overrun), 1);
    chk("ovr_taken", 32'(bus_if.out_valid), 0);

    // reset drops a presented average
    bus_if.out_ready = 1'b0;
    send(8'd80, 8'd50);
    repeat (3) @(negedge clk);
    chk("pre_rst_valid", 32'(bus_if.out_valid), 1);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(bus_if.out_valid), 0);
    chk("mid_rst_overrun", 32'(bus_if.overrun), 0);
    chk("mid_rst_avg_t", 32'(bus_if.avg_temperature), 0);
    chk("mid_rst_state", 32'(state_dbg), 0);
    chk("mid_rst_fill", 32'(fill_dbg), 0);
    reset = 1'b1;
    bus_if.out_ready = 1'b1;

    // temperatures 20,26,22,24
    send(8'd50, 8'd20);
    send(8'd50, 8'd26);
    send(8'd50, 8'd22);
    send(8'd50, 8'd24);
    repeat (2) @(negedge clk);
    chk("mm_valid", 32'(bus_if.out_valid), 1);
    chk("mm_avg_h_50", 32'(bus_if.avg_humidity), 50);
    chk("mm_avg_t_23", 32'(bus_if.avg_temperature), 23);
`ifdef DHT11_MINMAX_EN
    chk("min_t_20", 32'(bus_if.min_temperature), 20);
    chk("max_t_26", 32'(bus_if.max_temperature), 26);
`endif
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dht11_avg_reporter.md
DHT11_AVG_REPORTER -- requirements
Module: dht11_avg_reporter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000000, meaning cycles without a captured sample before stale asserts (2 s at 50 MHz).
REQ-002 SHALL have port clk  input  1  system clock, 50 MHz; all logic on posedge.
REQ-003 SHALL have port reset  input  1  synchronous active-low reset, sampled on posedge clk.
REQ-004 SHALL have port humidity  input  8  integer humidity from upstream DHT11 reader.
REQ-005 SHALL have port temperature  input  8  integer temperature from upstream DHT11 reader.
REQ-006 SHALL have port valid  input  1  upstream sample-valid level; may stay high for many cycles.
REQ-007 SHALL have port avg_humidity  output  8  4-sample mean humidity.
REQ-008 SHALL have port avg_temperature  output  8  4-sample mean temperature.
REQ-009 SHALL have port out_valid  output  1  average presented.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the average.
REQ-011 SHALL have port overrun  output  1  sticky; an unaccepted average was replaced.
REQ-012 SHALL have port reject  output  1  one-cycle pulse; out-of-range sample discarded.
REQ-013 SHALL have port stale  output  1  no sample captured for TIMEOUT_CYCLES.

Function
REQ-014 SHALL register valid and capture on its rising edge only (valid=1, previous valid=0); a held-high valid SHALL count as one sample.
REQ-015 SHALL discard any captured sample with humidity > 100 or temperature > 60, pulse reject for one cycle, and leave history, fill count and stale counter unchanged.
REQ-016 SHALL keep a 4-entry shift history per quantity; accepted sample enters entry 0, entry 3 is dropped.
REQ-017 SHALL keep a fill count 0..4, incremented per accepted sample, saturating at 4.
REQ-018 SHALL compute each average as a 10-bit sum of the 4 entries shifted right by 2 (truncation, no rounding).
REQ-019 SHALL implement FSM states FILL, CALC, OUT, WAIT.
REQ-020 FILL: accepted sample bringing fill count to 4 -> CALC; otherwise stay.
REQ-021 CALC: one cycle; load avg registers from current history -> OUT; an accepted sample in CALC SHALL shift history and go CALC again, without setting overrun.
REQ-022 OUT: out_valid=1, avg outputs stable; out_ready=1 -> WAIT; accepted sample without out_ready -> CALC and set overrun; accepted sample with out_ready in the same cycle -> CALC, no overrun.
REQ-023 WAIT: out_valid=0; accepted sample -> CALC.
REQ-024 Latency: out_valid SHALL rise 3 cycles after the posedge at which valid is first seen high (edge register, history update, CALC).
REQ-025 SHALL count cycles since last accepted sample, saturating; stale=1 when count >= TIMEOUT_CYCLES; accepted sample clears count and stale the next cycle.
REQ-026 avg outputs SHALL change only on CALC -> OUT.

Reset
REQ-027 With reset=0 at a posedge: state FILL, fill count 0, history 0, avg_humidity=0, avg_temperature=0, out_valid=0, overrun=0, reject=0, stale=0, stale counter 0, edge register 0.
REQ-028 Reset mid-operation SHALL drop a presented average without handshake; a valid held high across reset release SHALL NOT be captured until it falls and rises again.
REQ-029 overrun SHALL clear only by reset.

Configuration
REQ-030 Macro DHT11_MINMAX_EN: when defined, SHALL add outputs min_temperature and max_temperature (8 bits each), min/max of the 4 history entries, loaded in CALC with the averages, reset value 0.
REQ-031 Without DHT11_MINMAX_EN these ports and their logic SHALL be absent; all other behaviour identical.

Verification
REQ-032 Four valid pulses with (h,t)=(40,20),(42,22),(44,24),(46,26), out_ready=1 -> one out_valid, avg_humidity=43, avg_temperature=23, overrun=0.
REQ-033 valid held high 1000 cycles with (50,25) -> fill count 1, no out_valid.
REQ-034 Sample (101,20) -> reject pulse 1 cycle, fill count unchanged; (100,60) accepted.
REQ-035 After 4 samples, out_ready=0, fifth sample (60,30) -> out_valid stays high, averages reload, overrun=1 and stays 1.
REQ-036 TIMEOUT_CYCLES=100, no samples -> stale=1 at cycle 100 after reset release; next sample -> stale=0.
REQ-037 Reset=0 while out_valid=1 -> all outputs 0 next cycle, state FILL; with DHT11_MINMAX_EN, samples temp 20,26,22,24 -> min 20, max 26.
